// File: rtl/lpf_pkg.sv
// rtl/lpf_pkg.sv - shared width helpers, rounding constant and saturation for the LPF adder tree
package lpf_pkg;

    localparam int MAX_W = 128;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             sat;
    } sat_t;

    function automatic int lpf_lvl(input int num_in);
        return $clog2(num_in);
    endfunction

    function automatic int lpf_acc_w(input int in_w, input int num_in);
        return in_w + $clog2(num_in);
    endfunction

    // Operands still alive after l pairwise levels (odd ones pass through).
    function automatic int lpf_level_cnt(input int num_in, input int l);
        return (num_in + (1 << l) - 1) >> l;
    endfunction

    function automatic logic [MAX_W-1:0] lpf_round_const(input int shift);
        return (shift > 0) ? (MAX_W'(1) << (shift - 1)) : '0;
    endfunction

    function automatic sat_t lpf_saturate(input logic signed [MAX_W-1:0] value,
                                          input int                      out_width);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sat_t                    res;
        hi        = $signed((MAX_W'(1) << (out_width - 1)) - MAX_W'(1));
        lo        = ~hi;
        res.value = value;
        res.sat   = 1'b0;
        if (value > hi) begin
            res.value = hi;
            res.sat   = 1'b1;
        end else if (value < lo) begin
            res.value = lo;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lpf_add_stage.sv
// rtl/lpf_add_stage.sv - one registered adder-tree level: pairwise sums, odd passthrough, hold on stall
module lpf_add_stage #(
    parameter  int N_IN  = 2,
    parameter  int W     = 8,
    localparam int N_OUT = (N_IN + 1) / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               in_valid,
    input  logic [N_IN*W-1:0]  in_data,
    output logic               out_valid,
    output logic [N_OUT*W-1:0] out_data
);
    logic [N_OUT*W-1:0] sum;
    logic [N_OUT*W-1:0] data_d, data_q;
    logic               valid_d, valid_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_pair
        if (2 * k + 1 < N_IN) begin : g_add
            assign sum[k*W +: W] = in_data[2*k*W +: W] + in_data[(2*k+1)*W +: W];
        end else begin : g_pass
            assign sum[k*W +: W] = in_data[2*k*W +: W];
        end
    end

    always_comb begin
        data_d  = stall ? data_q : sum;
        valid_d = stall ? valid_q : in_valid;
    end

    // Data needs no reset; only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        data_q <= data_d;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/lpf_adder_tree.sv
// rtl/lpf_adder_tree.sv - pipelined signed adder tree with rounding shift, saturation and valid/ready
module lpf_adder_tree
    import lpf_pkg::*;
#(
    parameter int NUM_IN   = 8,
    parameter int IN_W     = 32,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0,
    parameter int SATURATE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);
    localparam int LVL   = lpf_lvl(NUM_IN);
    localparam int ACC_W = lpf_acc_w(IN_W, NUM_IN);

    logic                  stall;
    logic [ACC_W-1:0]      tree_sum;
    logic                  tree_valid;
    logic signed [ACC_W:0] rnd_sum, rnd_val;
    sat_t                  sat_res;
    logic [OUT_W-1:0]      res_data, out_data_d, out_data_q;
    logic                  res_sat, out_sat_d, out_sat_q;
    logic                  out_valid_d, out_valid_q;

    // One global stall keeps every stage in lockstep with the output register.
    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    for (genvar g = 0; g <= LVL; g++) begin : g_lvl
        localparam int CNT = lpf_level_cnt(NUM_IN, g);
        logic [CNT*ACC_W-1:0] data;
        logic                 valid;

        if (g == 0) begin : g_in
            logic [CNT*ACC_W-1:0] ext, data_d, data_q;
            logic                 valid_d, valid_q;

            for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
                assign ext[k*ACC_W +: ACC_W] =
                    {{LVL{in_data[k*IN_W+IN_W-1]}}, in_data[k*IN_W +: IN_W]};
            end

            always_comb begin
                data_d  = stall ? data_q : ext;
                valid_d = stall ? valid_q : in_valid;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
                data_q <= data_d;
            end

            assign data  = data_q;
            assign valid = valid_q;
        end else begin : g_add
            lpf_add_stage #(
                .N_IN (lpf_level_cnt(NUM_IN, g - 1)),
                .W    (ACC_W)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .stall     (stall),
                .in_valid  (g_lvl[g-1].valid),
                .in_data   (g_lvl[g-1].data),
                .out_valid (valid),
                .out_data  (data)
            );
        end
    end

    assign tree_sum   = g_lvl[LVL].data;
    assign tree_valid = g_lvl[LVL].valid;

    // One extra bit so the half-LSB rounding add cannot wrap.
    always_comb begin
        rnd_sum = $signed({tree_sum[ACC_W-1], tree_sum})
                + $signed((ACC_W+1)'(lpf_round_const(SHIFT)));
        rnd_val = rnd_sum >>> SHIFT;
        sat_res = lpf_saturate(MAX_W'(rnd_val), OUT_W);
        if (SATURATE != 0) begin
            res_data = sat_res.value[OUT_W-1:0];
            res_sat  = sat_res.sat;
        end else begin
            res_data = rnd_val[OUT_W-1:0];
            res_sat  = 1'b0;
        end
        out_valid_d = stall ? out_valid_q : tree_valid;
        out_data_d  = stall ? out_data_q  : res_data;
        out_sat_d   = stall ? out_sat_q   : res_sat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_lpf_adder_tree.sv
// tb/tb_lpf_adder_tree.sv - directed self-checking bench for lpf_adder_tree
module tb_lpf_adder_tree;

    typedef int vec8_t[8];
    typedef int vec5_t[5];

    localparam int MX = 32'h7FFF_FFFF;
    localparam int MN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic [255:0] data0, data1, data2;
    logic [159:0] data3;
    logic         in_ready0, in_ready1, in_ready2, in_ready3;
    logic         out_valid0, out_valid1, out_valid2, out_valid3;
    logic [31:0]  od0, od1, od2, od3;
    logic         osat0, osat1, osat2, osat3;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lpf_adder_tree u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(od0), .out_sat(osat0));

    lpf_adder_tree #(.SATURATE(0)) u_nosat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(od1), .out_sat(osat1));

    lpf_adder_tree #(.SHIFT(2)) u_shift (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(od2), .out_sat(osat2));

    lpf_adder_tree #(.NUM_IN(5)) u_five (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(data3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(od3), .out_sat(osat3));

    function automatic logic [255:0] pack8(input vec8_t v);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = v[k];
        return r;
    endfunction

    function automatic logic [159:0] pack5(input vec5_t v);
        logic [159:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = v[k];
        return r;
    endfunction

    function automatic logic [255:0] stream_vec(input int i);
        vec8_t v;
        for (int k = 0; k < 8; k++) v[k] = i * (k + 1) - 3 * k;
        return pack8(v);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic [255:0] v0, input logic [255:0] v1,
                           input logic [255:0] v2, input logic [159:0] v3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3,
                           input logic s0, input logic s1, input logic s3);
        @(negedge clk);
        data0 = v0; data1 = v1; data2 = v2; data3 = v3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check({tag, "_early_valid"}, 64'(out_valid0), 64'd0);
            @(negedge clk);
        end
        check({tag, "_early_valid"}, 64'(out_valid0), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'({out_valid0, out_valid1, out_valid2, out_valid3}), 64'hF);
        check({tag, "_def_data"},   64'(od0), 64'(e0));
        check({tag, "_def_sat"},    64'(osat0), 64'(s0));
        check({tag, "_nosat_data"}, 64'(od1), 64'(e1));
        check({tag, "_nosat_sat"},  64'(osat1), 64'(s1));
        check({tag, "_shift_data"}, 64'(od2), 64'(e2));
        check({tag, "_five_data"},  64'(od3), 64'(e3));
        check({tag, "_five_sat"},   64'(osat3), 64'(s3));
    endtask

    initial begin
        int          sent, rcvd, ghosts;
        logic [31:0] q[$];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'({out_valid0, out_valid1, out_valid2, out_valid3}), 64'd0);
        check("rst_out_data",  64'(od0), 64'd0);
        check("rst_out_sat",   64'(osat0), 64'd0);
        check("rst_in_ready",  64'({in_ready0, in_ready1, in_ready2, in_ready3}), 64'hF);
        rst_n = 1'b1;

        run_vec("a", pack8('{1, 2, 3, 4, 5, 6, 7, 8}), pack8('{MX, MX, MX, MX, MX, MX, MX, MX}),
                pack8('{5, 0, 0, 0, 0, 0, 0, 0}), pack5('{10, -3, 7, 1, -20}),
                32'd36, 32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
        run_vec("b", pack8('{MX, MX, MX, MX, MX, MX, MX, MX}), pack8('{1, 2, 3, 4, 5, 6, 7, 8}),
                pack8('{6, 0, 0, 0, 0, 0, 0, 0}), pack5('{100, 200, 300, 400, 500}),
                32'h7FFF_FFFF, 32'd36, 32'd2, 32'd1500, 1'b1, 1'b0, 1'b0);
        run_vec("c", pack8('{MN, MN, MN, MN, MN, MN, MN, MN}), pack8('{MN, MN, MN, MN, MN, MN, MN, MN}),
                pack8('{-6, 0, 0, 0, 0, 0, 0, 0}), pack5('{MX, MX, MX, MX, MX}),
                32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

        sent = 0; rcvd = 0;
        data1 = '0; data2 = '0; data3 = '0;
        for (int cyc = 0; cyc < 400 && rcvd < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 20);
            data0     = stream_vec(sent);
            #1;
            check("stream_in_ready", 64'(in_ready0), 64'(!(out_valid0 && !out_ready)));
            if (out_valid0 && out_ready) begin
                if (q.size() == 0) check("stream_extra", 64'(od0), 64'hDEAD);
                else               check("stream_data", 64'(od0), 64'(q.pop_front()));
                rcvd++;
            end
            if (in_valid && in_ready0) begin
                q.push_back(32'(36 * sent - 84));
                sent++;
            end
        end
        check("stream_count", 64'(rcvd), 64'd20);

        @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            data0 = pack8('{j + 1, 1, 1, 1, 1, 1, 1, 1});
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_valid", 64'({out_valid0, out_valid1, out_valid2, out_valid3}), 64'd0);
        ghosts = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (out_valid0 || out_valid3) ghosts++;
        end
        check("mid_rst_ghosts", 64'(ghosts), 64'd0);

        run_vec("d", pack8('{-1, -2, -3, -4, -5, -6, -7, -8}), pack8('{-1, -2, -3, -4, -5, -6, -7, -8}),
                pack8('{7, 0, 0, 0, 0, 0, 0, 0}), pack5('{MN, MN, MN, MN, MN}),
                32'hFFFF_FFDC, 32'hFFFF_FFDC, 32'd2, 32'h8000_0000, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
